// File: rtl/clkdiv_pkg.sv
// Shared defaults and helper functions for the multi-channel clock divider.
package clkdiv_pkg;

  localparam int DEF_NCH          = 4;
  localparam int DEF_DIV_W        = 32;
  localparam int DEF_CLK_IN_FREQ  = 50000000;
  localparam int DEF_DEFAULT_FREQ = 1000;

  // Reset half-period in input-clock cycles; a zero frequency yields 0.
  function automatic int calc_h0(int clk_hz, int freq_hz);
    return (freq_hz == 0) ? 0 : (clk_hz / 2) / freq_hz;
  endfunction

  // Width of the channel-select field; never narrower than one bit.
  function automatic int cfg_ch_width(int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/clkdiv_multi_if.sv
// Divisor-write request bus: the master offers a half-period for one channel.
interface clkdiv_multi_if
  import clkdiv_pkg::*;
#(
  parameter int NCH   = DEF_NCH,
  parameter int DIV_W = DEF_DIV_W
);
  localparam int CHW = cfg_ch_width(NCH);

  logic             cfg_valid;
  logic [CHW-1:0]   cfg_ch;
  logic [DIV_W-1:0] cfg_half;
  logic             cfg_ready;

  modport master (output cfg_valid, output cfg_ch, output cfg_half, input cfg_ready);
  modport slave  (input cfg_valid, input cfg_ch, input cfg_half, output cfg_ready);
endinterface

// File: rtl/clkdiv_chan.sv
// One divider channel: half-period counter, output toggle, tick and a
// pending divisor that only takes effect at a falling output edge.
module clkdiv_chan
  import clkdiv_pkg::*;
#(
  parameter int               DIV_W = DEF_DIV_W,
  parameter logic [DIV_W-1:0] H0    = '0
) (
  input  logic             clkin,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sync,
  input  logic             wr,
  input  logic [DIV_W-1:0] wr_half,
  output logic             clkout,
  output logic             tick,
  output logic             pend
);

  logic [DIV_W-1:0] count_q, count_d;
  logic [DIV_W-1:0] half_q, half_d;
  logic [DIV_W-1:0] per_q, per_d;
  logic             pend_q, pend_d;
  logic             clk_q, clk_d;
  logic             tick_q, tick_d;
  logic [DIV_W-1:0] cnt_inc;

  assign cnt_inc = count_q + DIV_W'(1);

  // Next-state: sync restart beats counting; pending divisor lands on a fall or when idle.
  always_comb begin
    count_d = count_q;
    half_d  = half_q;
    per_d   = per_q;
    pend_d  = pend_q;
    clk_d   = clk_q;
    tick_d  = 1'b0;
    if (sync) begin
      count_d = '0;
      clk_d   = 1'b0;
      if (pend_q) begin
        half_d = per_q;
        pend_d = 1'b0;
      end
    end else begin
      if (en) begin
        if (cnt_inc >= half_q) begin
          count_d = '0;
          clk_d   = ~clk_q;
          tick_d  = ~clk_q;
          if (clk_q && pend_q) begin
            half_d = per_q;
            pend_d = 1'b0;
          end
        end else begin
          count_d = cnt_inc;
        end
      end else if (pend_q) begin
        // An idle channel has no period in flight, so apply right away.
        half_d  = per_q;
        pend_d  = 1'b0;
        count_d = '0;
      end
      // A write is only accepted while nothing is pending, so it never races the apply above.
      if (wr) begin
        per_d  = wr_half;
        pend_d = 1'b1;
      end
    end
  end

  // Channel state register with asynchronous clear to the reset divisor.
  always_ff @(posedge clkin or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
      half_q  <= H0;
      per_q   <= '0;
      pend_q  <= 1'b0;
      clk_q   <= 1'b0;
      tick_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      half_q  <= half_d;
      per_q   <= per_d;
      pend_q  <= pend_d;
      clk_q   <= clk_d;
      tick_q  <= tick_d;
    end
  end

  assign clkout = clk_q;
  assign tick   = tick_q;
  assign pend   = pend_q;

endmodule

// File: rtl/clkdiv_multi.sv
// Multi-channel programmable clock divider: reset release synchroniser,
// divisor-write decode and ready muxing around NCH channel instances.
module clkdiv_multi
  import clkdiv_pkg::*;
#(
  parameter int NCH          = DEF_NCH,
  parameter int DIV_W        = DEF_DIV_W,
  parameter int CLK_IN_FREQ  = DEF_CLK_IN_FREQ,
  parameter int DEFAULT_FREQ = DEF_DEFAULT_FREQ
) (
  input  logic             clkin,
  input  logic             rst,
  input  logic [NCH-1:0]   clken,
  input  logic             sync,
  clkdiv_multi_if.slave    cfg,
  output logic [NCH-1:0]   clkout,
  output logic [NCH-1:0]   tick
);

  localparam logic [DIV_W-1:0] H0 = DIV_W'(calc_h0(CLK_IN_FREQ, DEFAULT_FREQ));

  logic [1:0]     rst_sync_q, rst_sync_d;
  logic           rst_n_int;
  logic [NCH-1:0] pend;
  logic [NCH-1:0] wr;
  logic           sel_pend;

  // Shift ones in behind a released reset.
  always_comb begin
    rst_sync_d = {rst_sync_q[0], 1'b1};
  end

  // Reset asserts immediately and releases two clkin edges later.
  always_ff @(posedge clkin or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= rst_sync_d;
    end
  end

  assign rst_n_int = rst_sync_q[1];

  // Pending flag of the addressed channel; unknown channels never block.
  always_comb begin
    sel_pend = 1'b0;
    if (int'(cfg.cfg_ch) < NCH) begin
      sel_pend = pend[cfg.cfg_ch];
    end
  end

  assign cfg.cfg_ready = ~sel_pend & ~sync;

  generate
    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
      assign wr[gi] = cfg.cfg_valid & cfg.cfg_ready & (int'(cfg.cfg_ch) == gi);

      clkdiv_chan #(
        .DIV_W (DIV_W),
        .H0    (H0)
      ) u_chan (
        .clkin   (clkin),
        .rst_n   (rst_n_int),
        .en      (clken[gi]),
        .sync    (sync),
        .wr      (wr[gi]),
        .wr_half (cfg.cfg_half),
        .clkout  (clkout[gi]),
        .tick    (tick[gi]),
        .pend    (pend[gi])
      );
    end
  endgenerate

endmodule

// File: tb/tb_clkdiv_multi.sv
// Randomised bench for clkdiv_multi against a "cycles remaining" reference model.
module tb_clkdiv_multi;
  import clkdiv_pkg::*;

  localparam int NCH          = 4;
  localparam int DIV_W        = 16;
  localparam int CLK_IN_FREQ  = 8000;
  localparam int DEFAULT_FREQ = 1000;
  localparam int H0           = 4;   // 8000 / 2 / 1000

  logic           clkin = 1'b0;
  logic           rst   = 1'b0;
  logic [NCH-1:0] clken;
  logic           sync;
  logic [NCH-1:0] clkout;
  logic [NCH-1:0] tick;

  clkdiv_multi_if #(.NCH(NCH), .DIV_W(DIV_W)) cfg_bus ();

  clkdiv_multi #(
    .NCH          (NCH),
    .DIV_W        (DIV_W),
    .CLK_IN_FREQ  (CLK_IN_FREQ),
    .DEFAULT_FREQ (DEFAULT_FREQ)
  ) dut (
    .clkin  (clkin),
    .rst    (rst),
    .clken  (clken),
    .sync   (sync),
    .cfg    (cfg_bus),
    .clkout (clkout),
    .tick   (tick)
  );

  always #5 clkin = ~clkin;

  int n_vec = 0;
  int n_err = 0;

  // Reference model: each channel tracks how many enabled cycles remain until it toggles.
  int m_h[NCH];
  int m_p[NCH];
  int m_rem[NCH];
  bit m_pend[NCH];
  bit m_lvl[NCH];
  bit m_tick[NCH];
  int hold;
  bit last_acc;

  task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s t=%0t got=%0h exp=%0h", tag, $time, got, exp);
    end
  endtask

  function automatic int max1(int h);
    return (h < 1) ? 1 : h;
  endfunction

  function automatic logic [31:0] pack_lvl();
    logic [31:0] v = '0;
    for (int i = 0; i < NCH; i++) v[i] = m_lvl[i];
    return v;
  endfunction

  function automatic logic [31:0] pack_tick();
    logic [31:0] v = '0;
    for (int i = 0; i < NCH; i++) v[i] = m_tick[i];
    return v;
  endfunction

  function automatic bit exp_ready();
    int ch = int'(cfg_bus.cfg_ch);
    if (sync) return 1'b0;
    if (ch < NCH) return !m_pend[ch];
    return 1'b1;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NCH; i++) begin
      m_h[i] = H0; m_p[i] = 0; m_pend[i] = 0;
      m_lvl[i] = 0; m_tick[i] = 0; m_rem[i] = max1(H0);
    end
    hold = 2;
  endtask

  task automatic apply_pend(int i);
    if (m_pend[i]) begin
      m_h[i] = m_p[i];
      m_pend[i] = 0;
    end
  endtask

  task automatic model_step(bit acc);
    int ch = int'(cfg_bus.cfg_ch);
    if (!rst) begin
      model_reset();
      return;
    end
    if (hold > 0) begin
      hold--;
      return;
    end
    for (int i = 0; i < NCH; i++) begin
      m_tick[i] = 0;
      if (sync) begin
        m_lvl[i] = 0;
        apply_pend(i);
        m_rem[i] = max1(m_h[i]);
      end else begin
        if (clken[i]) begin
          m_rem[i]--;
          if (m_rem[i] == 0) begin
            if (!m_lvl[i]) begin
              m_lvl[i] = 1;
              m_tick[i] = 1;
            end else begin
              m_lvl[i] = 0;
              apply_pend(i);
            end
            m_rem[i] = max1(m_h[i]);
          end
        end else if (m_pend[i]) begin
          apply_pend(i);
          m_rem[i] = max1(m_h[i]);
        end
        if (acc && ch == i) begin
          m_p[i] = int'(cfg_bus.cfg_half);
          m_pend[i] = 1;
        end
      end
    end
  endtask

  // One clkin cycle: check ready before the edge, advance model, check outputs after.
  task automatic cycle();
    bit r;
    #1;
    r = exp_ready();
    last_acc = cfg_bus.cfg_valid && r;
    check("cfg_ready", 32'(cfg_bus.cfg_ready), 32'(r));
    @(posedge clkin);
    model_step(last_acc);
    @(negedge clkin);
    check("clkout", 32'(clkout), pack_lvl());
    check("tick", 32'(tick), pack_tick());
  endtask

  task automatic run(int n);
    for (int k = 0; k < n; k++) cycle();
  endtask

  task automatic write_cfg(int ch, int half);
    bit done = 0;
    cfg_bus.cfg_valid = 1'b1;
    cfg_bus.cfg_ch    = 2'(ch);
    cfg_bus.cfg_half  = 16'(half);
    for (int k = 0; k < 40 && !done; k++) begin
      cycle();
      done = last_acc;
    end
    check("cfg_accept", 32'(done), 32'd1);
    $display("cfg write ch=%0d half=%0d accepted=%0d", ch, half, done);
    cfg_bus.cfg_valid = 1'b0;
  endtask

  task automatic reset_now();
    #2 rst = 1'b0;
    #1;
    check("rst_clkout", 32'(clkout), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    model_reset();
  endtask

  initial begin
    bit seen;
    clken = '1;
    sync = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    cfg_bus.cfg_ch = '0;
    cfg_bus.cfg_half = '0;
    model_reset();
    #1;
    check("por_clkout", 32'(clkout), 32'd0);
    check("por_tick", 32'(tick), 32'd0);
    @(negedge clkin);
    run(3);
    rst = 1'b1;
    $display("reset released, free-running H0=%0d", H0);
    run(26);

    // Divisor change requested while channel 1 is high.
    seen = 0;
    for (int k = 0; k < 20 && !seen; k++) begin
      if (m_lvl[1]) seen = 1; else cycle();
    end
    check("ch1_high_wait", 32'(seen), 32'd1);
    write_cfg(1, 2);
    run(20);

    // Freeze channel 2 mid-phase.
    run(3);
    clken[2] = 1'b0;
    $display("clken[2] low for 10 cycles");
    run(10);
    clken[2] = 1'b1;
    run(16);

    // Minimum half-periods on channel 3.
    write_cfg(3, 0);
    run(12);
    write_cfg(3, 1);
    run(12);

    // Skew ch0/ch1 at equal H, leave ch2 pending, then sync.
    write_cfg(1, 4);
    run(10);
    clken[1] = 1'b0;
    run(3);
    clken[1] = 1'b1;
    run(5);
    write_cfg(2, 3);
    sync = 1'b1;
    $display("sync pulse");
    cycle();
    sync = 1'b0;
    run(24);

    // Randomised traffic.
    for (int k = 0; k < 400; k++) begin
      for (int i = 0; i < NCH; i++) clken[i] = ($urandom_range(0, 9) != 0);
      sync = ($urandom_range(0, 49) == 0);
      cfg_bus.cfg_valid = ($urandom_range(0, 7) == 0);
      cfg_bus.cfg_ch    = 2'($urandom_range(0, NCH - 1));
      cfg_bus.cfg_half  = 16'($urandom_range(0, 6));
      cycle();
      if (last_acc)
        $display("rand cfg ch=%0d half=%0d accepted", cfg_bus.cfg_ch, cfg_bus.cfg_half);
    end
    clken = '1;
    sync = 1'b0;
    cfg_bus.cfg_valid = 1'b0;
    run(10);

    // Asynchronous reset while a write is pending.
    write_cfg(0, 6);
    run(2);
    reset_now();
    $display("async reset with pending write");
    run(2);
    rst = 1'b1;
    run(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/clkdiv_multi.md
CLKDIV_MULTI -- requirements
Module: clkdiv_multi

Interface
REQ-001 SHALL have parameter NCH, default 4, number of independent output channels (1..16).
REQ-002 SHALL have parameter DIV_W, default 32, width of the half-period divisor.
REQ-003 SHALL have parameter CLK_IN_FREQ, default 50000000, input clock frequency in Hz.
REQ-004 SHALL have parameter DEFAULT_FREQ, default 1000; reset half-period H0 = CLK_IN_FREQ/2/DEFAULT_FREQ, truncated to DIV_W bits.
REQ-005 clkin  input  1  single system clock; all logic on posedge.
REQ-006 rst  input  1  asynchronous, active-low reset.
REQ-007 clken  input  NCH  per-channel count enable.
REQ-008 sync  input  1  restarts all channels phase-aligned.
REQ-009 cfg_valid  input  1  divisor write request.
REQ-010 cfg_ch  input  max(1,clog2(NCH))  target channel of the write.
REQ-011 cfg_half  input  DIV_W  new half-period, in clkin cycles.
REQ-012 cfg_ready  output  1  write accepted when cfg_valid and cfg_ready are both high.
REQ-013 clkout  output  NCH  divided clock per channel, registered.
REQ-014 tick  output  NCH  one-cycle pulse per channel, registered.

Function
REQ-015 Each channel SHALL hold count (DIV_W), active half-period H (DIV_W), pending value P and pending flag pend.
REQ-016 When clken[i] is high, count SHALL increment; when count+1 >= H, count SHALL become 0 and clkout[i] SHALL toggle in that same clock edge.
REQ-017 H of 0 or 1 SHALL toggle clkout[i] every enabled cycle, giving a period of 2 cycles.
REQ-018 When clken[i] is low, count and clkout[i] SHALL hold their values and tick[i] SHALL be 0.
REQ-019 tick[i] SHALL be 1 for exactly the cycle in which clkout[i] has just gone 0->1, and 0 otherwise.
REQ-020 cfg_ready SHALL equal ~pend[cfg_ch] & ~sync; out-of-range cfg_ch (>= NCH) SHALL be accepted and discarded.
REQ-021 An accepted write SHALL load P=cfg_half and set pend on the next edge; H SHALL remain unchanged at that edge.
REQ-022 A pending value SHALL be applied (H<=P, pend<=0) on the edge where clkout[i] toggles 1->0, so every period already started completes at the old H.
REQ-023 If clken[i] is low while pend is set, P SHALL be applied on the next edge, with count cleared and clkout[i] held.
REQ-024 A write accepted in the same cycle as a toggle SHALL wait for the next qualifying 1->0 toggle.
REQ-025 sync high SHALL, on that edge, clear every count, drive every clkout and tick to 0, and apply every pending P; sync SHALL take priority over counting and cfg.
REQ-026 After sync is released, channels with equal H and clken held high SHALL remain edge-aligned indefinitely.
REQ-027 The count comparison SHALL use unsigned DIV_W arithmetic, and count SHALL never exceed max(H,1)-1 after its first wrap.

Reset
REQ-028 While rst is low: clkout=0, tick=0, count=0, H=H0, P=0, pend=0, immediately and independent of clkin.
REQ-029 Reset asserted mid-period or mid-pending SHALL discard the pending value; rst deassertion SHALL be synchronised internally with a 2-flop release.
REQ-030 The first rising edge of clkout[i] after reset release SHALL occur H0 enabled cycles after counting starts.

Structure
REQ-031 Package clkdiv_pkg SHALL hold the default parameter values, the H0 computation function and the cfg_ch width function.
REQ-032 Per-channel logic SHALL be sub-module clkdiv_chan, instantiated NCH times by generate; top-level logic is limited to cfg decode, ready muxing and reset synchroniser.

Verification (NCH=4, DIV_W=16, H0=4 via CLK_IN_FREQ=8000, DEFAULT_FREQ=1000)
REQ-033 Reset release, clken=4'hF -> each clkout rises 4 cycles after counting starts, period 8, tick every 8 cycles, all channels aligned.
REQ-034 Write ch1 cfg_half=2 while clkout[1] is high -> cfg_ready low until the next 1->0 toggle; the period in progress is 8, following periods are 4.
REQ-035 clken[2]=0 for 10 cycles mid-phase -> clkout[2] and count frozen, no tick; the phase resumes exactly where it stopped.
REQ-036 cfg_half=0, then 1, on ch3 -> clkout[3] toggles every cycle, tick every 2 cycles in both cases.
REQ-037 ch0 H=4, ch1 H=4 skewed by a clken gap, one-cycle sync -> all clkout 0 on the next edge, ch0/ch1 identical thereafter; a pending P is applied at sync.
REQ-038 rst low mid-period with pend set -> clkout=0 immediately, no clkin edge needed; after release H=H0 and the write is lost.
